// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
//   Byte-addressed data memory used by the RISC-V core's MEM stage. The storage
//   is an array of 32-bit words. Loads and stores of byte, halfword and word
//   size are selected by funct3. Stores merge bytes into the word through
//   per-lane enables. Loads return the selected byte or halfword shifted down
//   to bit 0 and sign- or zero-extended. Every accepted request gets a
//   registered response one cycle later. Stores respond too, so the pipeline
//   can retire or trap every access in the same way.
//
//   Accesses that cannot be served are flagged rather than aliased. An illegal
//   funct3, a misaligned address or an out-of-range address produces a fault
//   code. A faulting access never writes the array and returns zero data.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 4)
//   ADDR_W     request byte-address width (must be >= clog2(DEPTH)+2)
//   INIT_ZERO  simulation-only zero-fill request (no effect on this RTL)
//
// Ports
//   clk         core clock; all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   access request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V load/store funct3
//   req_addr    byte address
//   req_wdata   store data; SB/SH use the low bytes
//   req_ready   request is accepted when req_valid & req_ready (low in reset)
//   rsp_valid   response to the request accepted on the previous edge
//   rsp_rdata   extended load data (zero for stores and faults)
//   rsp_fault   00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
// -----------------------------------------------------------------------------
module data_mem_lsu #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_OOR = 2'b10;
  localparam logic [1:0] FLT_ILL = 2'b11;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_oor;
  logic             w_legal;
  logic             w_misaligned;
  logic [1:0]       w_fault;
  logic             w_store_en;
  logic             w_load_en;

  // Requests are refused while reset is high. A store presented during reset
  // is therefore never written.
  assign req_ready = ~rst;
  assign w_accept  = req_valid & ~rst;

  assign w_idx = req_addr[IDX_W+1:2];
  assign w_off = req_addr[1:0];

  // Any set address bit above the array span means the access is out of range.
  // When the address is exactly as wide as the array span, no such bit exists.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_oor
      assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  // Fault classification, highest priority first:
  // illegal funct3, then misalignment, then range.
  always_comb begin
    if (req_we) begin
      w_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      w_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    w_misaligned = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));

    if (!w_legal) begin
      w_fault = FLT_ILL;
    end else if (w_misaligned) begin
      w_fault = FLT_MIS;
    end else if (w_oor) begin
      w_fault = FLT_OOR;
    end else begin
      w_fault = FLT_OK;
    end
  end

  assign w_store_en = w_accept & req_we & (w_fault == FLT_OK);
  assign w_load_en  = w_accept & ~req_we;

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  w_be_base;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [3:0]  w_lane_we;
  logic [7:0]  w_lane_data [4];

  // The enable mask for the access size is anchored at lane 0 and then shifted
  // to the byte offset. Alignment was already checked, so the shifted mask
  // never runs off the top of the word when a write actually happens.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_be_base = 4'b0001;
      2'b01:   w_be_base = 4'b0011;
      default: w_be_base = 4'b1111;
    endcase
  end

  assign w_be       = w_be_base << w_off;
  assign w_wdata_sh = req_wdata << {w_off, 3'b000};

  // Lane k receives store-data byte (k - offset). The data shift above lines
  // the bytes up with their lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi]   = w_store_en & w_be[gi];
      assign w_lane_data[gi] = w_wdata_sh[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // The array and its read register are deliberately not reset, so the tools
  // can map them onto block RAM with a registered output.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_word;

  always_ff @(posedge clk) begin
    if (w_load_en) begin
      r_rd_word <= r_mem[w_idx];
    end
    for (int k = 0; k < 4; k++) begin
      if (w_lane_we[k]) begin
        r_mem[w_idx][8*k +: 8] <= w_lane_data[k];
      end
    end
  end

  // INIT_ZERO asks for a time-0 zero-fill, which only a simulation flow can
  // provide. The synthesizable array has no initial contents, so the parameter
  // is only sunk here.
  logic w_unused_init_zero;
  assign w_unused_init_zero = INIT_ZERO;

  // ---------------------------------------------------------------------------
  // Response control
  // ---------------------------------------------------------------------------
  logic       r_rsp_valid;
  logic [1:0] r_fault;
  logic       r_zero;
  logic [2:0] r_funct3;
  logic [1:0] r_off;

  // r_zero forces rsp_rdata to zero for stores, faults and the reset state.
  // Because of it, the non-reset read register never shows through at those
  // times. Without an accept, every field holds, so rsp_rdata and rsp_fault
  // keep their previous values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_fault     <= FLT_OK;
      r_zero      <= 1'b1;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_fault     <= w_fault;
      r_zero      <= req_we | (w_fault != FLT_OK);
      r_funct3    <= req_funct3;
      r_off       <= w_off;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  always_comb begin
    w_shifted = r_rd_word >> {r_off, 3'b000};
    w_ext     = '0;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};    // LB
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};  // LH
      3'b010:  w_ext = w_shifted;                                // LW
      3'b100:  w_ext = {24'h0, w_shifted[7:0]};                  // LBU
      3'b101:  w_ext = {16'h0, w_shifted[15:0]};                 // LHU
      default: w_ext = '0;
    endcase
  end

  assign rsp_rdata = r_zero ? 32'h0 : w_ext;
  assign rsp_fault = r_fault;

  // Reset drops a pending response immediately rather than one edge later.
  // This keeps a flushed access from retiring.
  assign rsp_valid = r_rsp_valid & ~rst;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_fault;

  always #5 clk = ~clk;

  data_mem_lsu #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .INIT_ZERO(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory kept as a flat byte array.
  logic [7:0] ref_mem [4*DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_fault = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: size in bytes, natural alignment and little-endian
  // byte assembly over the byte array.
  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic [1:0] flt);
    logic        legal;
    int          size;
    logic [31:0] val;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << f3[1:0];
    rd   = 32'h0;
    if (!legal)                    flt = 2'd3;
    else if ((addr % size) != 0)   flt = 2'd1;
    else if (addr >= 4 * DEPTH)    flt = 2'd2;
    else                           flt = 2'd0;
    if (flt == 2'd0) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
        rd = val;
      end
    end
  endfunction

  // Present one request for one cycle and push its expected response.
  // With use_lit set, the literal expectation is pushed instead of the model's.
  // The model is updated either way.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit use_lit,
                       input logic [31:0] lit_rd, input logic [1:0] lit_flt);
    exp_t        e;
    logic [31:0] rd;
    logic [1:0]  flt;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    ref_access(we, f3, addr, wdata, rd, flt);
    e.rdata = use_lit ? lit_rd : rd;
    e.fault = use_lit ? lit_flt : flt;
    e.due   = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Monitor: compares every response against the scoreboard, including the
  // cycle on which it arrives. It also checks hold behaviour on idle cycles.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("ready_in_rst", 32'(req_ready), 32'd0);
      check("valid_in_rst", 32'(rsp_valid), 32'd0);
    end else begin
      check("ready", 32'(req_ready), 32'd1);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp at cyc %0d: got rsp_valid=1, expected 0", cyc);
        end else begin
          e = sb_q.pop_front();
          check("rsp_cycle", cyc, e.due);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
          last_rdata = e.rdata;
          last_fault = e.fault;
          $display("rsp cyc=%0d rdata=%h fault=%0d", cyc, rsp_rdata, rsp_fault);
        end
      end else begin
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rsp at cyc %0d: got rsp_valid=0, expected 1", cyc);
          void'(sb_q.pop_front());
        end
        check("hold_rdata", rsp_rdata, last_rdata);
        check("hold_fault", 32'(rsp_fault), 32'(last_fault));
      end
    end
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          size;
    int          sel;

    // Reset then idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_fault", 32'(rsp_fault), 32'd0);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte merge and extension.
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 2'd0);
    issue(1'b1, 3'b000, 32'h11, 32'h0000007F, 1'b1, 32'h0, 2'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEAD7FEF, 2'd0);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 2'd0);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h000000DE, 2'd0);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFFDEAD, 2'd0);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 32'h00007FEF, 2'd0);
    idle();

    // Faults.
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 2'd1);
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1, 32'h0, 2'd0);
    issue(1'b1, 3'b001, 32'h21, 32'h00001234, 1'b1, 32'h0, 2'd1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 2'd0);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 2'd2);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2'd3);
    issue(1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 2'd3);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEAD7FEF, 2'd0);
    idle();

    // Streaming store then load to the same word.
    issue(1'b1, 3'b010, 32'h0, 32'h11111111, 1'b1, 32'h0, 2'd0);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 32'h11111111, 2'd0);
    idle();

    // Reset mid-operation.
    issue(1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 1'b1, 32'h0, 2'd0);
    idle();
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 2'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b0;
    sb_q.delete();
    last_rdata = '0;
    last_fault = '0;
    @(negedge clk);
    check("drop_on_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'h5A5A5A5A;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 2'd0);
    idle();

    // Fill the whole array, so random loads only see known data.
    for (int w = 0; w < DEPTH; w++) begin
      issue(1'b1, 3'b010, 32'(4 * w), $urandom, 1'b0, 32'h0, 2'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        we  = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 15);
        if (sel == 0) begin
          f3 = 3'($urandom_range(0, 7));
        end else if (we) begin
          f3 = 3'($urandom_range(0, 2));
        end else begin
          case ($urandom_range(0, 4))
            0:       f3 = 3'b000;
            1:       f3 = 3'b001;
            2:       f3 = 3'b010;
            3:       f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
        size = 1 << f3[1:0];
        if ($urandom_range(0, 15) == 0) begin
          addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
        end else begin
          addr = 32'($urandom_range(0, 4 * DEPTH - 1));
        end
        if ($urandom_range(0, 3) != 0 && size <= 4) addr = addr & ~32'(size - 1);
        issue(we, f3, addr, $urandom, 1'b0, 32'h0, 2'd0);
      end
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Byte-addressed, parametrised RISC-V data memory for the single-cycle/pipelined core's MEM stage.
- Replaces the word-indexed 32-bit RAM.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW via funct3, with byte-lane write merging, sign/zero extension and registered (1-cycle) read response.
- Flags misaligned, out-of-range and illegal-size accesses instead of silently aliasing.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two, ≥4).
- ADDR_W, 32, request address width in bits.
- INIT_ZERO, 0, 1 = simulation-only zero-fill of the array at time 0 (never driven by reset).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- req_ready  out  1  request accepted when req_valid & req_ready.
- rsp_valid  out  1  response for request accepted previous cycle.
- rsp_rdata  out  32  extended load data.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=00. req_ready=0 while rst is high, 1 otherwise. Memory array is not reset.
- Word index = req_addr[clog2(DEPTH)+1:2]; byte offset = req_addr[1:0].
- Fault checks are evaluated combinationally at accept, in priority order:
  - Illegal: load funct3 ∈ {011,110,111}; store funct3 ≠ {000,001,010}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
  - Out of range: req_addr ≥ 4*DEPTH (upper address bits nonzero).
- Faulting request: no array write; response carries the fault code and rdata=0.
- Store (no fault):
  - Byte enables: SB = 1 lane at offset; SH = 2 lanes at offset (0 or 2); SW = all 4.
  - Lane k gets req_wdata byte (k - offset).
  - Write lands at the accepting edge. Unselected lanes keep their old value.
- Load (no fault):
  - Word is read at the accepting edge into a registered path.
  - Selected byte/halfword is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passthrough.
- Latency: response is registered and asserts exactly 1 cycle after accept.
  - rsp_valid=1 for one cycle per accepted request.
  - Back-to-back requests each cycle give a continuous rsp_valid stream, in order.
- Stores also respond (rsp_valid=1, rdata=0, fault code) so the pipeline can retire or trap uniformly.
- Read-after-write: a load accepted the cycle after a store to the same word returns post-store data.
- Only one access per cycle exists, so there is no same-cycle read/write conflict.
- No accept while req_valid=0: rsp_valid=0 next cycle, and rsp_rdata/rsp_fault hold their previous values.
- Reset asserted while a response is pending:
  - The pending response is dropped (rsp_valid=0 next cycle).
  - A store accepted on the same edge as rst is NOT written, since req_ready=0 during rst.
- Address wrap: none. Addresses beyond the array fault rather than alias.

Test Plan:
- Reset then idle: rst high 2 cycles → rsp_valid=0, rsp_rdata=0, rsp_fault=00, req_ready=0; req_ready=1 the cycle after rst drops.
- SW 0xDEADBEEF @0x10; SB 0x7F @0x11; LW @0x10 → rdata 0xDEAD7FEF, fault 00; each rsp_valid one cycle after its request.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x00007FEF.
- Faults:
  - LW @0x12 → fault 01, rdata 0.
  - SH @0x21 → fault 01 and word 0x20 unchanged.
  - LW @4*DEPTH (0x400) → fault 10.
  - funct3=011 load → fault 11.
  - funct3=100 store → fault 11, no write.
- Streaming: SW 0x11111111 @0x0 then LW @0x0 on consecutive cycles → second response 0x11111111; rsp_valid high 2 consecutive cycles.
- Reset mid-operation: accept LW, assert rst next cycle → rsp_valid=0 that cycle. SW issued with rst high → a later LW shows the old data.
